// File: rtl/adder_tree_pkg.sv
// Shared definitions for the adder tree front end and its frame bookkeeping.
package adder_tree_pkg;

  typedef enum logic {
    FILL,
    STALL
  } state_e;

  // Width that can hold a lane count from 0 up to and including n.
  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/adder_tree_lane_packer.sv
// Packs a serial valid/ready sample stream into zero-padded INPUTS_NUM-lane
// frames for the adder tree's parallel input.
module adder_tree_lane_packer
  import adder_tree_pkg::*;
#(
  parameter int INPUTS_NUM  = 128,
  parameter int IDATA_WIDTH = 24,
  parameter int CNT_WIDTH   = count_width(INPUTS_NUM)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [IDATA_WIDTH-1:0] s_data,
  input  logic                   s_last,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [IDATA_WIDTH-1:0] m_data [INPUTS_NUM],
  output logic [CNT_WIDTH-1:0]   m_count
);

  typedef logic [IDATA_WIDTH-1:0] lane_t;

  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(INPUTS_NUM - 1);

  state_e               state;
  logic [CNT_WIDTH-1:0] idx;
  logic [CNT_WIDTH-1:0] pending;
  lane_t                fill [INPUTS_NUM];

  logic                 accept;
  logic                 slot_free;
  logic                 completing;
  logic                 xfer;
  logic [CNT_WIDTH-1:0] xfer_count;
  lane_t                frame [INPUTS_NUM];

  // NOTE: every signal written here gets a default first, so no path leaves a value held (no latch).
  always_comb begin
    accept     = s_valid && s_ready;
    slot_free  = !m_valid || m_ready;
    completing = accept && (s_last || idx == LAST_IDX);
    xfer       = 1'b0;
    xfer_count = pending;
    if (state == FILL) begin
      xfer       = completing && slot_free;
      xfer_count = idx + CNT_WIDTH'(1);
    end else begin
      xfer       = slot_free;
      xfer_count = pending;
    end
    // Lanes beyond the frame length may hold stale samples; mask them to zero.
    for (int i = 0; i < INPUTS_NUM; i++) begin
      frame[i] = '0;
      if (CNT_WIDTH'(i) < xfer_count) begin
        frame[i] = (state == FILL && CNT_WIDTH'(i) == idx) ? s_data : fill[i];
      end
    end
  end

  // NOTE: the fill buffer is pure datapath storage and is not reset; stale lanes are never exposed.
  always_ff @(posedge clk) begin
    if (accept) fill[idx] <= s_data;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every block sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= FILL;
      idx     <= '0;
      pending <= '0;
      s_ready <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          s_ready <= 1'b1;
          if (accept) begin
            if (completing) begin
              idx <= '0;
              if (!slot_free) begin
                pending <= idx + CNT_WIDTH'(1);
                state   <= STALL;
                s_ready <= 1'b0;
              end
            end else begin
              idx <= idx + CNT_WIDTH'(1);
            end
          end
        end
        STALL: begin
          if (slot_free) begin
            idx     <= '0;
            state   <= FILL;
            s_ready <= 1'b1;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_count <= '0;
      for (int i = 0; i < INPUTS_NUM; i++) m_data[i] <= '0;
    end else if (xfer) begin
      m_valid <= 1'b1;
      m_count <= xfer_count;
      m_data  <= frame;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule
